// File: rtl/tid_stamp_fifo_if.sv
// Bus bundle for the tid-stamping request FIFO.
//
// Handshake semantics (the only place they are written down):
//   - Producer side: write_en is a push request. It is accepted on a rising
//     clk edge only when full is low at that edge; a push while full is
//     dropped and latches overflow_error.
//   - Consumer side: valid_out high means meta_out/tid_out hold the head
//     entry. read_en pops the head on a rising edge only when valid_out is
//     high at that edge; a read while empty latches underflow_error.
//   - full, almfull and valid_out depend only on registered occupancy, so
//     neither side sees a combinational path from its own inputs.
interface tid_stamp_fifo_if #(
  parameter int HDR_WIDTH   = 64,
  parameter int TID_WIDTH   = 32,
  parameter int DEPTH_BASE2 = 3
);
  logic                   write_en;
  logic [HDR_WIDTH-1:0]   meta_in;
  logic                   full;
  logic                   almfull;
  logic                   read_en;
  logic                   valid_out;
  logic [HDR_WIDTH-1:0]   meta_out;
  logic [TID_WIDTH-1:0]   tid_out;
  logic [DEPTH_BASE2:0]   count;
  logic                   overflow_error;
  logic                   underflow_error;

  // Producer/consumer environment side.
  modport master (
    output write_en, meta_in, read_en,
    input  full, almfull, valid_out, meta_out, tid_out, count,
           overflow_error, underflow_error
  );

  // FIFO side.
  modport slave (
    input  write_en, meta_in, read_en,
    output full, almfull, valid_out, meta_out, tid_out, count,
           overflow_error, underflow_error
  );
endinterface

// File: rtl/tid_stamp_fifo.sv
// Request FIFO that stamps each accepted header with a wrapping transaction
// ID and presents {meta, tid} first-word-fall-through to a checker.
module tid_stamp_fifo #(
  parameter int HDR_WIDTH      = 64,
  parameter int TID_WIDTH      = 32,
  parameter int DEPTH_BASE2    = 3,
  parameter int ALMFULL_THRESH = 2
) (
  input logic             clk,
  input logic             rst_n,
  tid_stamp_fifo_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_BASE2;
  localparam logic [DEPTH_BASE2:0] C_DEPTH   = (DEPTH_BASE2+1)'(DEPTH);
  localparam logic [DEPTH_BASE2:0] C_ALMFULL = (DEPTH_BASE2+1)'(DEPTH - ALMFULL_THRESH);

  // Storage is deliberately not reset; only pointers and count are.
  logic [HDR_WIDTH-1:0]   r_meta_mem [DEPTH];
  logic [TID_WIDTH-1:0]   r_tid_mem  [DEPTH];
  logic [DEPTH_BASE2-1:0] r_wr_ptr;
  logic [DEPTH_BASE2-1:0] r_rd_ptr;
  logic [DEPTH_BASE2:0]   r_count;
  logic [TID_WIDTH-1:0]   r_tid_ctr;
  logic                   r_overflow;
  logic                   r_underflow;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Flags come from the pre-edge count, so a read on a full FIFO cannot
  // make room for a write in the same cycle.
  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_push  = bus.write_en && !w_full;
  assign w_pop   = bus.read_en  && !w_empty;

  // Capture the header together with the tid it was stamped with.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_meta_mem[r_wr_ptr] <= bus.meta_in;
      r_tid_mem[r_wr_ptr]  <= r_tid_ctr;
    end
  end

  // Pointers and tid counter; tid advances only on accepted pushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_tid_ctr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + 1'b1;
        r_tid_ctr <= r_tid_ctr + TID_WIDTH'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy tracks push/pop; simultaneous push and pop cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky misuse flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.write_en && w_full) begin
        r_overflow <= 1'b1;
      end
      if (bus.read_en && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Head data is masked to zero while empty so the checker never sees stale
  // storage contents.
  assign bus.full            = w_full;
  assign bus.almfull         = (r_count >= C_ALMFULL);
  assign bus.valid_out       = !w_empty;
  assign bus.meta_out        = w_empty ? '0 : r_meta_mem[r_rd_ptr];
  assign bus.tid_out         = w_empty ? '0 : r_tid_mem[r_rd_ptr];
  assign bus.count           = r_count;
  assign bus.overflow_error  = r_overflow;
  assign bus.underflow_error = r_underflow;
endmodule

// File: tb/tb_tid_stamp_fifo.sv
// Bench for tid_stamp_fifo: a default-size instance checked against a
// queue-based reference model, plus a 4-bit-tid instance for wraparound.
module tb_tid_stamp_fifo;
  logic clk;
  logic rst_n;

  int n_tests;
  int n_fail;

  // Reference model: FIFO contents as queues, next tid, sticky flags.
  logic [63:0] mq_meta[$];
  logic [31:0] mq_tid[$];
  logic [31:0] m_tid;
  bit          m_ovf;
  bit          m_unf;

  tid_stamp_fifo_if #(.HDR_WIDTH(64), .TID_WIDTH(32), .DEPTH_BASE2(3)) bus ();
  tid_stamp_fifo_if #(.HDR_WIDTH(8),  .TID_WIDTH(4),  .DEPTH_BASE2(3)) bus2 ();

  tid_stamp_fifo #(
    .HDR_WIDTH(64), .TID_WIDTH(32), .DEPTH_BASE2(3), .ALMFULL_THRESH(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  tid_stamp_fifo #(
    .HDR_WIDTH(8), .TID_WIDTH(4), .DEPTH_BASE2(3), .ALMFULL_THRESH(2)
  ) dut_w4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_clear();
    mq_meta.delete();
    mq_tid.delete();
    m_tid = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic do_reset();
    bus.write_en  = 1'b0;
    bus.read_en   = 1'b0;
    bus.meta_in   = '0;
    bus2.write_en = 1'b0;
    bus2.read_en  = 1'b0;
    bus2.meta_in  = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // Driver: apply one cycle of stimulus, then advance the model by the
  // FIFO rules using the occupancy seen before the edge.
  task automatic drive_cycle(input bit we, input logic [63:0] meta, input bit re);
    bit pre_full;
    bit pre_valid;
    bus.write_en = we;
    bus.meta_in  = meta;
    bus.read_en  = re;
    pre_full  = (mq_meta.size() == 8);
    pre_valid = (mq_meta.size() != 0);
    @(posedge clk);
    #1;
    if (re) begin
      if (pre_valid) begin
        void'(mq_meta.pop_front());
        void'(mq_tid.pop_front());
      end else begin
        m_unf = 1'b1;
      end
    end
    if (we) begin
      if (!pre_full) begin
        mq_meta.push_back(meta);
        mq_tid.push_back(m_tid);
        m_tid = m_tid + 1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    n_tests++;
    if (bus.valid_out !== 1'b0 || bus.full !== 1'b0 || bus.almfull !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: valid=%0b full=%0b almfull=%0b expected 0/0/0", bus.valid_out, bus.full, bus.almfull);
    end
    n_tests++;
    if (bus.meta_out !== 64'd0 || bus.tid_out !== 32'd0) begin
      n_fail++; $display("FAIL reset_data: meta=%0h tid=%0h expected 0/0", bus.meta_out, bus.tid_out);
    end
    n_tests++;
    if (bus.overflow_error !== 1'b0 || bus.underflow_error !== 1'b0) begin
      n_fail++; $display("FAIL reset_errors: ovf=%0b unf=%0b expected 0/0", bus.overflow_error, bus.underflow_error);
    end
  endtask

  // Three headers written back to back, consumer reads whenever data is shown.
  task automatic test_basic();
    logic [63:0] hdr [3];
    int seen;
    hdr[0] = 64'hA0; hdr[1] = 64'hA1; hdr[2] = 64'hA2;
    seen = 0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive_cycle(c < 3, (c < 3) ? hdr[c] : 64'd0, (mq_meta.size() != 0));
      n_tests++;
      if (bus.valid_out !== (c < 3)) begin
        n_fail++; $display("FAIL basic_valid c%0d: got %0b expected %0b", c, bus.valid_out, (c < 3));
      end
      if (c < 3) begin
        n_tests++;
        if (bus.tid_out !== 32'(c) || bus.meta_out !== hdr[c]) begin
          n_fail++; $display("FAIL basic_head c%0d: tid=%0d meta=%0h expected tid=%0d meta=%0h", c, bus.tid_out, bus.meta_out, c, hdr[c]);
        end
        seen++;
      end
    end
    n_tests++;
    if (bus.overflow_error !== 1'b0 || bus.underflow_error !== 1'b0 || seen != 3) begin
      n_fail++; $display("FAIL basic_errors: ovf=%0b unf=%0b expected 0/0", bus.overflow_error, bus.underflow_error);
    end
  endtask

  // Fill to full, overflow once, then drain and confirm the dropped write
  // did not consume a tid.
  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 64'($urandom), 1'b0);
      n_tests++;
      if (bus.count !== 4'(i + 1) || bus.almfull !== (i + 1 >= 6) || bus.full !== (i == 7)) begin
        n_fail++; $display("FAIL fill_level %0d: count=%0d almfull=%0b full=%0b expected %0d/%0b/%0b",
                           i, bus.count, bus.almfull, bus.full, i + 1, (i + 1 >= 6), (i == 7));
      end
    end
    drive_cycle(1'b1, 64'hDEAD, 1'b0);
    n_tests++;
    if (bus.overflow_error !== 1'b1 || bus.count !== 4'd8 || bus.underflow_error !== 1'b0) begin
      n_fail++; $display("FAIL fill_overflow: ovf=%0b count=%0d unf=%0b expected 1/8/0", bus.overflow_error, bus.count, bus.underflow_error);
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (bus.valid_out !== 1'b1 || bus.tid_out !== 32'(i) || bus.meta_out !== mq_meta[0]) begin
        n_fail++; $display("FAIL fill_drain %0d: valid=%0b tid=%0d meta=%0h expected 1/%0d/%0h", i, bus.valid_out, bus.tid_out, bus.meta_out, i, mq_meta[0]);
      end
      drive_cycle(1'b0, 64'd0, 1'b1);
    end
    n_tests++;
    if (bus.valid_out !== 1'b0 || bus.count !== 4'd0) begin
      n_fail++; $display("FAIL fill_empty: valid=%0b count=%0d expected 0/0", bus.valid_out, bus.count);
    end
    drive_cycle(1'b1, 64'h55, 1'b0);
    n_tests++;
    if (bus.tid_out !== 32'd8) begin
      n_fail++; $display("FAIL fill_next_tid: got %0d expected 8", bus.tid_out);
    end
  endtask

  // Read on empty, then simultaneous write+read on empty.
  task automatic test_underflow();
    do_reset();
    drive_cycle(1'b0, 64'd0, 1'b1);
    n_tests++;
    if (bus.underflow_error !== 1'b1 || bus.count !== 4'd0 || bus.valid_out !== 1'b0) begin
      n_fail++; $display("FAIL unf_empty_read: unf=%0b count=%0d valid=%0b expected 1/0/0", bus.underflow_error, bus.count, bus.valid_out);
    end
    drive_cycle(1'b1, 64'h77, 1'b1);
    n_tests++;
    if (bus.count !== 4'd1 || bus.valid_out !== 1'b1 || bus.tid_out !== 32'd0 || bus.meta_out !== 64'h77) begin
      n_fail++; $display("FAIL unf_wr_rd: count=%0d valid=%0b tid=%0d meta=%0h expected 1/1/0/77", bus.count, bus.valid_out, bus.tid_out, bus.meta_out);
    end
    n_tests++;
    if (bus.underflow_error !== 1'b1 || bus.overflow_error !== 1'b0) begin
      n_fail++; $display("FAIL unf_sticky: unf=%0b ovf=%0b expected 1/0", bus.underflow_error, bus.overflow_error);
    end
  endtask

  // Write+read on a full FIFO: pop happens, write is rejected.
  task automatic test_full_rw();
    do_reset();
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, 64'(100 + i), 1'b0);
    drive_cycle(1'b1, 64'hBAD, 1'b1);
    n_tests++;
    if (bus.count !== 4'd7 || bus.overflow_error !== 1'b1 || bus.tid_out !== 32'd1 || bus.meta_out !== 64'd101) begin
      n_fail++; $display("FAIL full_rw: count=%0d ovf=%0b tid=%0d meta=%0h expected 7/1/1/65", bus.count, bus.overflow_error, bus.tid_out, bus.meta_out);
    end
    for (int i = 1; i < 8; i++) begin
      n_tests++;
      if (bus.tid_out !== 32'(i) || bus.meta_out !== 64'(100 + i)) begin
        n_fail++; $display("FAIL full_rw_drain %0d: tid=%0d meta=%0h expected %0d/%0h", i, bus.tid_out, bus.meta_out, i, 100 + i);
      end
      drive_cycle(1'b0, 64'd0, 1'b1);
    end
    drive_cycle(1'b1, 64'h88, 1'b0);
    n_tests++;
    if (bus.tid_out !== 32'd8 || bus.meta_out !== 64'h88) begin
      n_fail++; $display("FAIL full_rw_next_tid: tid=%0d meta=%0h expected 8/88", bus.tid_out, bus.meta_out);
    end
  endtask

  // Random traffic, every output compared to the model each cycle.
  task automatic test_random();
    logic [63:0] exp_meta;
    logic [31:0] exp_tid;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drive_cycle($urandom_range(0, 99) < 60, {$urandom, $urandom}, $urandom_range(0, 99) < 45);
      exp_meta = (mq_meta.size() != 0) ? mq_meta[0] : 64'd0;
      exp_tid  = (mq_tid.size()  != 0) ? mq_tid[0]  : 32'd0;
      n_tests++;
      if (bus.count !== 4'(mq_meta.size()) || bus.valid_out !== (mq_meta.size() != 0) ||
          bus.full !== (mq_meta.size() == 8) || bus.almfull !== (mq_meta.size() >= 6)) begin
        n_fail++; $display("FAIL rand_level c%0d: count=%0d valid=%0b full=%0b almfull=%0b expected count=%0d",
                           c, bus.count, bus.valid_out, bus.full, bus.almfull, mq_meta.size());
      end
      n_tests++;
      if (bus.meta_out !== exp_meta || bus.tid_out !== exp_tid) begin
        n_fail++; $display("FAIL rand_head c%0d: meta=%0h tid=%0d expected %0h/%0d", c, bus.meta_out, bus.tid_out, exp_meta, exp_tid);
      end
      n_tests++;
      if (bus.overflow_error !== m_ovf || bus.underflow_error !== m_unf) begin
        n_fail++; $display("FAIL rand_errors c%0d: ovf=%0b unf=%0b expected %0b/%0b", c, bus.overflow_error, bus.underflow_error, m_ovf, m_unf);
      end
    end
  endtask

  // 4-bit tid instance: 18 writes with a reader tracking it, tids wrap 15->0.
  task automatic test_wrap();
    int wc;
    int rc;
    bit pre_valid;
    bit pre_full;
    do_reset();
    wc = 0;
    rc = 0;
    for (int c = 0; c < 21; c++) begin
      bus2.write_en = (c < 18);
      bus2.meta_in  = 8'(c);
      bus2.read_en  = (wc > rc);
      pre_valid = (wc > rc);
      pre_full  = (wc - rc == 8);
      @(posedge clk);
      #1;
      if (bus2.read_en && pre_valid) rc++;
      if (bus2.write_en && !pre_full) wc++;
      if (wc > rc) begin
        n_tests++;
        if (bus2.valid_out !== 1'b1 || bus2.tid_out !== 4'(rc % 16) || bus2.meta_out !== 8'(rc)) begin
          n_fail++; $display("FAIL wrap_head c%0d: valid=%0b tid=%0d meta=%0d expected 1/%0d/%0d", c, bus2.valid_out, bus2.tid_out, bus2.meta_out, rc % 16, rc);
        end
      end
    end
    bus2.write_en = 1'b0;
    bus2.read_en  = 1'b0;
    n_tests++;
    if (bus2.valid_out !== 1'b0 || bus2.count !== 4'd0 || bus2.overflow_error !== 1'b0 || bus2.underflow_error !== 1'b0) begin
      n_fail++; $display("FAIL wrap_end: valid=%0b count=%0d ovf=%0b unf=%0b expected 0/0/0/0",
                         bus2.valid_out, bus2.count, bus2.overflow_error, bus2.underflow_error);
    end
  endtask

  // Asynchronous reset with entries buffered; old entries must vanish.
  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 64'(200 + i), 1'b0);
    drive_cycle(1'b0, 64'd0, 1'b1);
    drive_cycle(1'b1, 64'hEE, 1'b1);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.valid_out !== 1'b0 || bus.count !== 4'd0 || bus.meta_out !== 64'd0 || bus.tid_out !== 32'd0) begin
      n_fail++; $display("FAIL rstmid_async: valid=%0b count=%0d meta=%0h tid=%0d expected all 0",
                         bus.valid_out, bus.count, bus.meta_out, bus.tid_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    drive_cycle(1'b1, 64'h1234, 1'b0);
    n_tests++;
    if (bus.tid_out !== 32'd0 || bus.meta_out !== 64'h1234 || bus.count !== 4'd1) begin
      n_fail++; $display("FAIL rstmid_first: tid=%0d meta=%0h count=%0d expected 0/1234/1", bus.tid_out, bus.meta_out, bus.count);
    end
    drive_cycle(1'b0, 64'd0, 1'b1);
    drive_cycle(1'b0, 64'd0, 1'b0);
    n_tests++;
    if (bus.valid_out !== 1'b0 || bus.count !== 4'd0 || bus.underflow_error !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_drain: valid=%0b count=%0d unf=%0b expected 0/0/0", bus.valid_out, bus.count, bus.underflow_error);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic();
    test_fill();
    test_underflow();
    test_full_rw();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
